// File: rtl/sc_run_ctrl.sv
// sc_run_ctrl: sequences the CPU reset, counts RUN cycles and ends a run on halt or cycle budget.
// Optional stable-PC loop detection is enabled by defining SC_RUN_CTRL_LOOP_DETECT_EN.
module sc_run_ctrl #(
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 31,
  parameter int LOOP_CYCLES  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 core_reset,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0]       RST_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [RCW-1:0]       RST_ONE  = RCW'(32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);

  state_t               state_q, state_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic                 core_reset_q, core_reset_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic                 run_entry_s;
  logic                 loop_hit_s;

  assign cnt_inc_s = cycle_count_q + CNT_ONE;

`ifdef SC_RUN_CTRL_LOOP_DETECT_EN
  localparam int LCW = $clog2(LOOP_CYCLES);
  localparam logic [LCW-1:0] LOOP_LAST = LCW'(LOOP_CYCLES - 2);
  localparam logic [LCW-1:0] LOOP_ONE  = LCW'(32'd1);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                pc_vld_q, pc_vld_d;
  logic [LCW-1:0]      stable_q, stable_d;
  logic                pc_same_s;

  // The first RUN edge has no previous PC to compare against, hence pc_vld.
  assign pc_same_s  = pc_vld_q && (pc == pc_q);
  assign loop_hit_s = pc_same_s && (stable_q == LOOP_LAST);

  // Loop-detect next state: track PC and count consecutive unchanged edges.
  always_comb begin
    pc_d     = pc_q;
    pc_vld_d = pc_vld_q;
    stable_d = stable_q;
    if (run_entry_s) begin
      pc_vld_d = 1'b0;
      stable_d = {LCW{1'b0}};
    end else if (state_q == ST_RUN) begin
      pc_d     = pc;
      pc_vld_d = 1'b1;
      if (pc_same_s) begin
        stable_d = stable_q + LOOP_ONE;
      end else begin
        stable_d = {LCW{1'b0}};
      end
    end else begin
      pc_vld_d = pc_vld_q;
    end
  end

  // Loop-detect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= {PC_WIDTH{1'b0}};
      pc_vld_q <= 1'b0;
      stable_q <= {LCW{1'b0}};
    end else begin
      pc_q     <= pc_d;
      pc_vld_q <= pc_vld_d;
      stable_q <= stable_d;
    end
  end
`else
  localparam int UNUSED_LOOP_CYCLES = LOOP_CYCLES;
  logic unused_pc_s;

  assign unused_pc_s = ^pc;
  assign loop_hit_s  = 1'b0;
`endif

  // Run FSM next state and registered-output values.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    core_reset_d  = core_reset_q;
    running_d     = running_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    run_entry_s   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        core_reset_d = 1'b1;
        running_d    = 1'b0;
        if (start) begin
          state_d       = ST_RESET;
          rst_cnt_d     = {RCW{1'b0}};
          done_d        = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = {CNT_WIDTH{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d      = ST_RUN;
          core_reset_d = 1'b0;
          running_d    = 1'b1;
          run_entry_s  = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_ONE;
        end
      end
      ST_RUN: begin
        cycle_count_d = cnt_inc_s;
        // Halt (or a detected loop) takes priority over the budget at the same edge.
        if (halt || loop_hit_s) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          timeout_d    = 1'b0;
          running_d    = 1'b0;
          core_reset_d = 1'b1;
        end else if (cnt_inc_s == CNT_MAX) begin
          state_d      = ST_DONE;
          done_d       = 1'b1;
          timeout_d    = 1'b1;
          running_d    = 1'b0;
          core_reset_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        core_reset_d = 1'b1;
        running_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rst_cnt_q     <= {RCW{1'b0}};
      core_reset_q  <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      core_reset_q  <= core_reset_d;
      running_q     <= running_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sc_run_ctrl.sv
// tb_sc_run_ctrl: table-driven runs with a scoreboard queue, plus hand-written
// sequences for async reset mid-run and a MAX_CYCLES=8 instance.
module tb_sc_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt;
  logic [31:0] pc;

  logic        core_reset_a, running_a, done_a, timeout_a;
  logic [15:0] cycle_count_a;
  logic        core_reset_b, running_b, done_b, timeout_b;
  logic [15:0] cycle_count_b;

  bit          use8_sel = 1'b0;
  logic        o_core_reset, o_running, o_done, o_timeout;
  logic [15:0] o_cnt;

  int total = 0;
  int bad   = 0;

  sc_run_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pc(pc),
    .core_reset(core_reset_a), .running(running_a), .done(done_a),
    .timeout(timeout_a), .cycle_count(cycle_count_a)
  );

  sc_run_ctrl #(.MAX_CYCLES(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .pc(pc),
    .core_reset(core_reset_b), .running(running_b), .done(done_b),
    .timeout(timeout_b), .cycle_count(cycle_count_b)
  );

  always #5 clk = ~clk;

  assign o_core_reset = use8_sel ? core_reset_b  : core_reset_a;
  assign o_running    = use8_sel ? running_b     : running_a;
  assign o_done       = use8_sel ? done_b        : done_a;
  assign o_timeout    = use8_sel ? timeout_b     : timeout_a;
  assign o_cnt        = use8_sel ? cycle_count_b : cycle_count_a;

  typedef struct {
    string       name;
    logic [15:0] cnt;
    logic        timeout;
    int          edges;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string name;
    int    halt_edge;
    int    pc_hold;
    int    exp_cnt;
    logic  exp_to;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    logic d;
    e.name    = v.name;
    e.cnt     = 16'(v.exp_cnt);
    e.timeout = v.exp_to;
    e.edges   = v.exp_cnt;
    sb_q.push_back(e);
    do_start();
    chk({v.name, "_clr_cnt"}, 32'(o_cnt), 32'd0);
    chk({v.name, "_clr_done"}, 32'(o_done), 32'd0);
    chk({v.name, "_rst1_core"}, 32'(o_core_reset), 32'd1);
    step();
    chk({v.name, "_rst2_run"}, 32'(o_running), 32'd0);
    step();
    chk({v.name, "_run_on"}, 32'(o_running), 32'd1);
    chk({v.name, "_core_off"}, 32'(o_core_reset), 32'd0);
    n = 0;
    d = 1'b0;
    while (!d && n < 40) begin
      n++;
      halt = (n == v.halt_edge);
      pc   = (v.pc_hold != 0 && n >= v.pc_hold) ? 32'h40 : 32'h1000 + 32'(4 * n);
      step();
      d = o_done;
    end
    halt = 1'b0;
    e = sb_q.pop_front();
    chk({e.name, "_edges"}, 32'(n), 32'(e.edges));
    chk({e.name, "_cnt"}, 32'(o_cnt), 32'(e.cnt));
    chk({e.name, "_done"}, 32'(o_done), 32'd1);
    chk({e.name, "_timeout"}, 32'(o_timeout), 32'(e.timeout));
    chk({e.name, "_running"}, 32'(o_running), 32'd0);
    chk({e.name, "_core"}, 32'(o_core_reset), 32'd1);
    step();
    chk({e.name, "_hold_cnt"}, 32'(o_cnt), 32'(e.cnt));
    chk({e.name, "_hold_done"}, 32'(o_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{"halt10", 10, 0, 10, 1'b0};
    vecs[1] = '{"budget", 0, 0, 31, 1'b1};
    vecs[2] = '{"halt1", 1, 0, 1, 1'b0};
    vecs[3] = '{"both31", 31, 0, 31, 1'b0};
`ifdef SC_RUN_CTRL_LOOP_DETECT_EN
    vecs[4] = '{"loop", 0, 3, 6, 1'b0};
`else
    vecs[4] = '{"loop", 0, 3, 31, 1'b1};
`endif

    reset = 1'b1;
    start = 1'b0;
    halt  = 1'b0;
    pc    = 32'h0;
    step();
    step();
    chk("rst_core", 32'(core_reset_a), 32'd1);
    chk("rst_running", 32'(running_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_timeout", 32'(timeout_a), 32'd0);
    chk("rst_cnt", 32'(cycle_count_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("idle_core", 32'(core_reset_a), 32'd1);
    chk("idle_running", 32'(running_a), 32'd0);

    use8_sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
    end

    reset_pulse();
    use8_sel = 1'b1;
    v = '{"max8_halt8", 8, 0, 8, 1'b0};
    run_vec(v);
    v = '{"max8_budget", 0, 0, 8, 1'b1};
    run_vec(v);

    // Async reset between edges in the middle of a run.
    reset_pulse();
    use8_sel = 1'b0;
    do_start();
    step();
    step();
    for (int n = 1; n <= 5; n++) begin
      start = (n == 2);
      step();
    end
    start = 1'b0;
    chk("mid_cnt5", 32'(cycle_count_a), 32'd5);
    chk("mid_start_ignored", 32'(running_a), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_cnt", 32'(cycle_count_a), 32'd0);
    chk("async_running", 32'(running_a), 32'd0);
    chk("async_core", 32'(core_reset_a), 32'd1);
    chk("async_done", 32'(done_a), 32'd0);
    #2;
    reset = 1'b0;
    v = '{"rerun_halt3", 3, 0, 3, 1'b0};
    run_vec(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
